// File: rtl/aer_receiver_control.sv
`default_nettype none
// ==========================================================================
// aer_receiver_control : four-phase AER symbol receiver and frame decoder
// (Fs, C, X0, D, Fe). Optional watchdog built when AER_RX_TIMEOUT_EN is set.
// Rev 1.0
// ==========================================================================
module aer_receiver_control (
  input  logic clk,
  input  logic reset,
  input  logic Fs,
  input  logic Zero,
  input  logic One,
  input  logic X0,
  input  logic Fe,
  output logic Fs_d,
  output logic Zero_d,
  output logic One_d,
  output logic X0_d,
  output logic Fe_d,
  output logic Ch1,
  output logic Ch2,
  output logic Up,
  output logic Down,
  output logic ev_valid,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_CH  = 3'd1,
    W_SEP = 3'd2,
    W_DIR = 3'd3,
    W_FE  = 3'd4
  } state_t;

  localparam int c_fs   = 0;
  localparam int c_zero = 1;
  localparam int c_one  = 2;
  localparam int c_x0   = 3;
  localparam int c_fe   = 4;

  logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
  state_t     state_q, state_d, ret_q, ret_d;
  logic       ack_q, ack_d, multi_q, multi_d, emit_q, emit_d;
  logic [4:0] ack_line_q, ack_line_d;
  logic [1:0] chan_q, chan_d;   // {ch1, ch2}
  logic [1:0] dir_q, dir_d;     // {up, down}
  logic [3:0] fields_q, fields_d;
  logic       ev_valid_q, ev_valid_d, err_q, err_d;
  logic       w_onehot;
`ifdef AER_RX_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       w_change;
`endif

  assign w_onehot = ((sync2_q & (sync2_q - 5'd1)) == 5'd0);

  always_comb begin
    sync1_d    = {Fe, X0, One, Zero, Fs};
    sync2_d    = sync1_q;
    state_d    = state_q;
    ret_d      = ret_q;
    ack_d      = ack_q;
    multi_d    = multi_q;
    emit_d     = emit_q;
    ack_line_d = ack_line_q;
    chan_d     = chan_q;
    dir_d      = dir_q;
    fields_d   = 4'b0000;
    ev_valid_d = 1'b0;
    err_d      = 1'b0;

    if (ack_q) begin
      // Handshake completes once the acknowledged line has returned low.
      if ((sync2_q & ack_line_q) == 5'd0) begin
        ack_line_d = 5'd0;
        ack_d      = 1'b0;
        emit_d     = 1'b0;
        state_d    = ret_q;
        if (emit_q) begin
          ev_valid_d = 1'b1;
          fields_d   = {chan_q, dir_q};
          chan_d     = 2'b00;
          dir_d      = 2'b00;
        end
      end
    end else if (multi_q) begin
      if (sync2_q == 5'd0) begin
        multi_d = 1'b0;
      end
    end else if (sync2_q != 5'd0) begin
      if (!w_onehot) begin
        err_d   = 1'b1;
        multi_d = 1'b1;
      end else begin
        ack_d      = 1'b1;
        ack_line_d = sync2_q;
        emit_d     = 1'b0;
        if (sync2_q[c_fs]) begin
          ret_d = W_CH;
          if (state_q != IDLE) begin
            err_d  = 1'b1;
            chan_d = 2'b00;
            dir_d  = 2'b00;
          end
        end else if (state_q == W_CH && (sync2_q[c_zero] || sync2_q[c_one])) begin
          chan_d = sync2_q[c_one] ? 2'b10 : 2'b01;
          ret_d  = W_SEP;
        end else if (state_q == W_SEP && sync2_q[c_x0]) begin
          ret_d = W_DIR;
        end else if (state_q == W_DIR && (sync2_q[c_zero] || sync2_q[c_one])) begin
          dir_d = sync2_q[c_one] ? 2'b10 : 2'b01;
          ret_d = W_FE;
        end else if (state_q == W_FE && sync2_q[c_fe]) begin
          ret_d  = IDLE;
          emit_d = 1'b1;
        end else begin
          err_d  = 1'b1;
          ret_d  = IDLE;
          chan_d = 2'b00;
          dir_d  = 2'b00;
        end
      end
    end

`ifdef AER_RX_TIMEOUT_EN
    w_change = (state_d != state_q) || (ack_d != ack_q) || (multi_d != multi_q);
    wd_d     = 8'd0;
    if (!w_change && (state_q != IDLE || ack_q)) begin
      // Counter reaches 255 on this edge: abandon the frame.
      if (wd_q == 8'd254) begin
        err_d      = 1'b1;
        ack_line_d = 5'd0;
        ack_d      = 1'b0;
        multi_d    = 1'b0;
        emit_d     = 1'b0;
        chan_d     = 2'b00;
        dir_d      = 2'b00;
        state_d    = IDLE;
        ret_d      = IDLE;
      end else begin
        wd_d = wd_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 5'd0;
      sync2_q    <= 5'd0;
      state_q    <= IDLE;
      ret_q      <= IDLE;
      ack_q      <= 1'b0;
      multi_q    <= 1'b0;
      emit_q     <= 1'b0;
      ack_line_q <= 5'd0;
      chan_q     <= 2'b00;
      dir_q      <= 2'b00;
      fields_q   <= 4'b0000;
      ev_valid_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef AER_RX_TIMEOUT_EN
      wd_q       <= 8'd0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      ret_q      <= ret_d;
      ack_q      <= ack_d;
      multi_q    <= multi_d;
      emit_q     <= emit_d;
      ack_line_q <= ack_line_d;
      chan_q     <= chan_d;
      dir_q      <= dir_d;
      fields_q   <= fields_d;
      ev_valid_q <= ev_valid_d;
      err_q      <= err_d;
`ifdef AER_RX_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign Fs_d     = ack_line_q[c_fs];
  assign Zero_d   = ack_line_q[c_zero];
  assign One_d    = ack_line_q[c_one];
  assign X0_d     = ack_line_q[c_x0];
  assign Fe_d     = ack_line_q[c_fe];
  assign Ch1      = fields_q[3];
  assign Ch2      = fields_q[2];
  assign Up       = fields_q[1];
  assign Down     = fields_q[0];
  assign ev_valid = ev_valid_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aer_receiver_control.sv
`default_nettype none
// ==========================================================================
// tb_aer_receiver_control : randomized four-phase sender against a
// frame-position reference model. Rev 1.0
// ==========================================================================
module tb_aer_receiver_control;

  localparam int c_fs   = 0;
  localparam int c_zero = 1;
  localparam int c_one  = 2;
  localparam int c_x0   = 3;
  localparam int c_fe   = 4;

  logic       clk;
  logic       reset;
  logic [4:0] lines;
  logic       Fs_d, Zero_d, One_d, X0_d, Fe_d;
  logic       Ch1, Ch2, Up, Down, ev_valid, err;
  logic [4:0] dvec;

  assign dvec = {Fe_d, X0_d, One_d, Zero_d, Fs_d};

  aer_receiver_control dut (
    .clk      (clk),
    .reset    (reset),
    .Fs       (lines[c_fs]),
    .Zero     (lines[c_zero]),
    .One      (lines[c_one]),
    .X0       (lines[c_x0]),
    .Fe       (lines[c_fe]),
    .Fs_d     (Fs_d),
    .Zero_d   (Zero_d),
    .One_d    (One_d),
    .X0_d     (X0_d),
    .Fe_d     (Fe_d),
    .Ch1      (Ch1),
    .Ch2      (Ch2),
    .Up       (Up),
    .Down     (Down),
    .ev_valid (ev_valid),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Observed activity
  int         ev_cnt  = 0;
  int         err_cnt = 0;
  int         viol    = 0;
  logic [3:0] last_fields = 4'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ev_valid) begin
        ev_cnt = ev_cnt + 1;
        last_fields = {Ch1, Ch2, Up, Down};
        if (!((Ch1 ^ Ch2) && (Up ^ Down))) viol = viol + 1;
      end else if ({Ch1, Ch2, Up, Down} != 4'b0) begin
        viol = viol + 1;
      end
      if (err) begin
        err_cnt = err_cnt + 1;
        if (ev_valid) viol = viol + 1;
      end
      if ((dvec & (dvec - 5'd1)) != 5'd0) viol = viol + 1;
    end
  end

  // Reference model: position within the five-symbol frame
  int         pos = 0;
  logic [3:0] m_fields = 4'b0;
  int         exp_ev = 0;
  int         exp_err = 0;
  logic [3:0] exp_fields = 4'b0;

  task automatic model_sym(input int s);
    bit ok;
    ok = (pos == 0 && s == c_fs) ||
         (pos == 1 && (s == c_zero || s == c_one)) ||
         (pos == 2 && s == c_x0) ||
         (pos == 3 && (s == c_zero || s == c_one)) ||
         (pos == 4 && s == c_fe);
    if (s == c_fs) begin
      if (pos != 0) exp_err++;
      pos = 1;
      m_fields = 4'b0;
    end else if (ok) begin
      if (pos == 1) m_fields[3:2] = (s == c_one) ? 2'b10 : 2'b01;
      if (pos == 3) m_fields[1:0] = (s == c_one) ? 2'b10 : 2'b01;
      if (pos == 4) begin
        exp_ev++;
        exp_fields = m_fields;
        m_fields = 4'b0;
        pos = 0;
      end else begin
        pos++;
      end
    end else begin
      exp_err++;
      pos = 0;
      m_fields = 4'b0;
    end
  endtask

  task automatic send_sym(input int s);
    int n;
    int prev_ev;
    prev_ev = exp_ev;
    @(posedge clk); #1 lines[s] = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (dvec[s]) break;
    end
    chk("d_rise_edges", n, 3);
    chk("d_onehot", 32'(dvec), 32'(1) << s);
    @(posedge clk); #1 lines[s] = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!dvec[s]) break;
    end
    chk("d_fall_edges", n, 3);
    @(posedge clk); #1;
    model_sym(s);
    chk("err_count", err_cnt, exp_err);
    chk("ev_count", ev_cnt, exp_ev);
    if (exp_ev != prev_ev) chk("ev_fields", 32'(last_fields), 32'(exp_fields));
  endtask

  task automatic send_frame(input int c, input int d);
    send_sym(c_fs);
    send_sym(c);
    send_sym(c_x0);
    send_sym(d);
    send_sym(c_fe);
  endtask

  task automatic inject_multi(input int a, input int b);
    int seen;
    seen = 0;
    @(posedge clk); #1 lines[a] = 1'b1; lines[b] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (dvec != 5'd0) seen++;
    end
    @(posedge clk); #1 lines = 5'd0;
    repeat (5) begin
      @(negedge clk);
      if (dvec != 5'd0) seen++;
    end
    exp_err++;
    chk("multi_no_d", seen, 0);
    chk("multi_err", err_cnt, exp_err);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_d"}, 32'(dvec), 0);
    chk({tag, "_fields"}, 32'({Ch1, Ch2, Up, Down}), 0);
    chk({tag, "_ev"}, 32'(ev_valid), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    int n;
    lines = 5'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Directed frames
    send_frame(c_zero, c_one);
    send_frame(c_one, c_zero);

    // Fe in place of X0, then a clean frame
    send_sym(c_fs);
    send_sym(c_zero);
    send_sym(c_fe);
    send_frame(c_one, c_one);

    // Two lines at once while waiting for the channel
    send_sym(c_fs);
    inject_multi(c_zero, c_one);
    send_sym(c_one);
    send_sym(c_x0);
    send_sym(c_zero);
    send_sym(c_fe);

    // Reset while X0 is being acknowledged
    send_sym(c_fs);
    send_sym(c_zero);
    @(posedge clk); #1 lines[c_x0] = 1'b1;
    n = 0;
    while (n < 20 && !X0_d) begin
      @(negedge clk); n++;
    end
    chk("x0_ack_seen", 32'(X0_d), 1);
    @(posedge clk); #1 reset = 1'b1; lines = 5'd0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_quiet("midreset");
    pos = 0;
    m_fields = 4'b0;
    send_frame(c_zero, c_zero);

    // Idle sender after Fs
    send_sym(c_fs);
    repeat (300) @(posedge clk);
    #1;
`ifdef AER_RX_TIMEOUT_EN
    exp_err++;
    pos = 0;
    m_fields = 4'b0;
`endif
    chk("watchdog_err", err_cnt, exp_err);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        send_frame($urandom_range(0, 1) ? c_one : c_zero,
                   $urandom_range(0, 1) ? c_one : c_zero);
      end else if (kind < 9) begin
        int len;
        len = $urandom_range(1, 5);
        for (int k = 0; k < len; k++) send_sym($urandom_range(0, 4));
      end else begin
        int a;
        a = $urandom_range(0, 4);
        inject_multi(a, (a + $urandom_range(1, 4)) % 5);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_err_count", err_cnt, exp_err);
    chk("final_ev_count", ev_cnt, exp_ev);
    chk("monitor_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
